// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between the instruction-fetch requester (read-only)
// and the load/store requester (read/write). Each requester may have one
// transaction outstanding; the memory carries one transaction at a time.
// Simultaneous candidates are resolved round-robin against the last grant.
//
// Ports:
//   clock, reset                    clock; asynchronous active-high reset
//   ifu_reqValid, ifu_addr          fetch request pulse + address
//   ifu_respValid, ifu_rdata        fetch completion pulse + data
//   lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask
//                                   load/store request pulse + payload
//   lsu_respValid, lsu_rdata        load/store completion pulse + load data
//   mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask
//                                   memory request pulse + payload
//   mem_respValid, mem_rdata        memory completion pulse + read data
//   busy                            any transaction pending, issuing or waiting
//   drop_err                        sticky: a request arrived while outstanding
module mem_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    output logic        mem_reqValid,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        drop_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
    typedef enum logic {PORT_IFU, PORT_LSU} port_t;

    state_t      state_q, state_d;
    port_t       owner_q, owner_d;
    port_t       last_grant_q, last_grant_d;

    logic        ifu_pending_q, ifu_pending_d;
    logic [31:0] ifu_addr_q, ifu_addr_d;
    logic        lsu_pending_q, lsu_pending_d;
    logic [31:0] lsu_addr_q, lsu_addr_d;
    logic [1:0]  lsu_size_q, lsu_size_d;
    logic        lsu_wen_q, lsu_wen_d;
    logic [31:0] lsu_wdata_q, lsu_wdata_d;
    logic [3:0]  lsu_wmask_q, lsu_wmask_d;

    logic [31:0] mem_addr_q, mem_addr_d;
    logic [1:0]  mem_size_q, mem_size_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;

    logic        ifu_resp_q, ifu_resp_d;
    logic [31:0] ifu_rdata_q, ifu_rdata_d;
    logic        lsu_resp_q, lsu_resp_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;
    logic        drop_err_q, drop_err_d;

    logic        ifu_out, lsu_out;
    logic        ifu_cand, lsu_cand;
    logic        pick_lsu;
    logic        complete;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        ifu_pending_d = ifu_pending_q;
        ifu_addr_d    = ifu_addr_q;
        lsu_pending_d = lsu_pending_q;
        lsu_addr_d    = lsu_addr_q;
        lsu_size_d    = lsu_size_q;
        lsu_wen_d     = lsu_wen_q;
        lsu_wdata_d   = lsu_wdata_q;
        lsu_wmask_d   = lsu_wmask_q;
        mem_addr_d    = mem_addr_q;
        mem_size_d    = mem_size_q;
        mem_wen_d     = mem_wen_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wmask_d   = mem_wmask_q;
        ifu_resp_d    = 1'b0;
        ifu_rdata_d   = ifu_rdata_q;
        lsu_resp_d    = 1'b0;
        lsu_rdata_d   = lsu_rdata_q;
        drop_err_d    = drop_err_q;
        pick_lsu      = 1'b0;
        complete      = 1'b0;

        // Outstanding = captured but not yet granted, or owning the memory.
        // The owner stops being outstanding once the FSM is back in IDLE,
        // which lets a port re-request in the same cycle as its respValid.
        ifu_out = ifu_pending_q | ((state_q != ST_IDLE) && (owner_q == PORT_IFU));
        lsu_out = lsu_pending_q | ((state_q != ST_IDLE) && (owner_q == PORT_LSU));

        if (ifu_reqValid) begin
            if (ifu_out) begin
                drop_err_d = 1'b1;
            end else begin
                ifu_pending_d = 1'b1;
                ifu_addr_d    = ifu_addr;
            end
        end
        if (lsu_reqValid) begin
            if (lsu_out) begin
                drop_err_d = 1'b1;
            end else begin
                lsu_pending_d = 1'b1;
                lsu_addr_d    = lsu_addr;
                lsu_size_d    = lsu_size;
                lsu_wen_d     = lsu_wen;
                lsu_wdata_d   = lsu_wdata;
                lsu_wmask_d   = lsu_wmask;
            end
        end

        ifu_cand = ifu_pending_q | (ifu_reqValid & ~ifu_out);
        lsu_cand = lsu_pending_q | (lsu_reqValid & ~lsu_out);

        case (state_q)
            ST_IDLE: begin
                if (ifu_cand || lsu_cand) begin
                    pick_lsu = lsu_cand && (!ifu_cand || (last_grant_q == PORT_IFU));
                    state_d  = ST_ISSUE;
                    if (pick_lsu) begin
                        owner_d       = PORT_LSU;
                        lsu_pending_d = 1'b0;
                        // A pending port cannot have accepted a new request
                        // this cycle, so pending selects the captured payload.
                        if (lsu_pending_q) begin
                            mem_addr_d  = lsu_addr_q;
                            mem_size_d  = lsu_size_q;
                            mem_wen_d   = lsu_wen_q;
                            mem_wdata_d = lsu_wdata_q;
                            mem_wmask_d = lsu_wmask_q;
                        end else begin
                            mem_addr_d  = lsu_addr;
                            mem_size_d  = lsu_size;
                            mem_wen_d   = lsu_wen;
                            mem_wdata_d = lsu_wdata;
                            mem_wmask_d = lsu_wmask;
                        end
                    end else begin
                        owner_d       = PORT_IFU;
                        ifu_pending_d = 1'b0;
                        mem_addr_d    = ifu_pending_q ? ifu_addr_q : ifu_addr;
                        mem_size_d    = 2'b10;
                        mem_wen_d     = 1'b0;
                        mem_wdata_d   = '0;
                        mem_wmask_d   = '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_respValid) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_respValid) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (complete) begin
            last_grant_d = owner_q;
            if (owner_q == PORT_LSU) begin
                lsu_resp_d  = 1'b1;
                lsu_rdata_d = mem_rdata;
            end else begin
                ifu_resp_d  = 1'b1;
                ifu_rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= PORT_IFU;
            last_grant_q  <= PORT_LSU;
            ifu_pending_q <= 1'b0;
            ifu_addr_q    <= '0;
            lsu_pending_q <= 1'b0;
            lsu_addr_q    <= '0;
            lsu_size_q    <= '0;
            lsu_wen_q     <= 1'b0;
            lsu_wdata_q   <= '0;
            lsu_wmask_q   <= '0;
            mem_addr_q    <= '0;
            mem_size_q    <= '0;
            mem_wen_q     <= 1'b0;
            mem_wdata_q   <= '0;
            mem_wmask_q   <= '0;
            ifu_resp_q    <= 1'b0;
            ifu_rdata_q   <= '0;
            lsu_resp_q    <= 1'b0;
            lsu_rdata_q   <= '0;
            drop_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            ifu_pending_q <= ifu_pending_d;
            ifu_addr_q    <= ifu_addr_d;
            lsu_pending_q <= lsu_pending_d;
            lsu_addr_q    <= lsu_addr_d;
            lsu_size_q    <= lsu_size_d;
            lsu_wen_q     <= lsu_wen_d;
            lsu_wdata_q   <= lsu_wdata_d;
            lsu_wmask_q   <= lsu_wmask_d;
            mem_addr_q    <= mem_addr_d;
            mem_size_q    <= mem_size_d;
            mem_wen_q     <= mem_wen_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wmask_q   <= mem_wmask_d;
            ifu_resp_q    <= ifu_resp_d;
            ifu_rdata_q   <= ifu_rdata_d;
            lsu_resp_q    <= lsu_resp_d;
            lsu_rdata_q   <= lsu_rdata_d;
            drop_err_q    <= drop_err_d;
        end
    end

    assign ifu_respValid = ifu_resp_q;
    assign ifu_rdata     = ifu_rdata_q;
    assign lsu_respValid = lsu_resp_q;
    assign lsu_rdata     = lsu_rdata_q;
    assign mem_reqValid  = (state_q == ST_ISSUE);
    assign mem_addr      = mem_addr_q;
    assign mem_size      = mem_size_q;
    assign mem_wen       = mem_wen_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;
    assign busy          = (state_q != ST_IDLE) | ifu_pending_q | lsu_pending_q;
    assign drop_err      = drop_err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one memory port between the instruction-fetch requester (read-only) and the load/store requester (read/write). Each side may have at most one transaction outstanding, and the memory carries at most one transaction at a time. Simultaneous requests are resolved round-robin. The block sits between the core's `io_ifu_*` / `io_lsu_*` ports and the single SoC memory bus, and it uses the same reqValid/respValid pulse handshake on all three sides.

## Interface
- No parameters. Data and address width is 32 bits, fixed.
- `clock` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `ifu_reqValid` in 1: one-cycle fetch request pulse; `ifu_addr` is valid in the same cycle.
- `ifu_addr` in 32: fetch address.
- `ifu_respValid` out 1: one-cycle pulse when fetch data is ready.
- `ifu_rdata` out 32: fetch data, valid while `ifu_respValid` is high.
- `lsu_reqValid` in 1: one-cycle load/store request pulse; the LSU payload is valid in the same cycle.
- `lsu_addr` in 32: load/store address.
- `lsu_size` in 2: access size.
- `lsu_wen` in 1: write enable.
- `lsu_wdata` in 32: write data.
- `lsu_wmask` in 4: write byte mask.
- `lsu_respValid` out 1: one-cycle completion pulse (loads and stores).
- `lsu_rdata` out 32: load data, valid while `lsu_respValid` is high.
- `mem_reqValid` out 1: one-cycle request pulse to memory.
- `mem_addr` out 32, `mem_size` out 2, `mem_wen` out 1, `mem_wdata` out 32, `mem_wmask` out 4: memory request payload.
- `mem_respValid` in 1: one-cycle completion pulse from memory.
- `mem_rdata` in 32: memory read data.
- `busy` out 1: high while any transaction is pending, issuing or waiting.
- `drop_err` out 1: sticky flag, set when a request was dropped.

## Operation
- Per port, the block keeps a pending flag plus a captured payload register (IFU: address only; LSU: full payload).
- A port is *outstanding* from the cycle its reqValid is accepted until the cycle before its respValid.
- A reqValid on a port that is already outstanding is dropped. The pending payload is unchanged and `drop_err` is set; it clears only on reset.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: the candidates are each port's pending flag OR'd with that port's incoming reqValid (bypass).
    - One candidate: grant it.
    - Both candidates: grant the port that was not granted last.
    - On a grant: latch the owner, load the `mem_*` payload from the captured or incoming payload, clear that port's pending flag, and go to ISSUE.
  - ISSUE: `mem_reqValid`=1 for exactly this cycle.
    - If `mem_respValid`=1 in this cycle, complete and go to IDLE.
    - Otherwise go to WAIT.
  - WAIT: stay until `mem_respValid`=1, then complete and go to IDLE.
- Complete: register `mem_rdata` into the owner's rdata output and pulse the owner's respValid on the next cycle. Update `last_grant` to the owner.
- IFU transactions drive `mem_size`=2'b10, `mem_wen`=0, `mem_wmask`=4'b0000, `mem_wdata`=0.
- LSU transactions pass `lsu_size`, `lsu_wen`, `lsu_wdata` and `lsu_wmask` through unchanged.
- The `mem_*` payload is held stable from ISSUE until completion. It keeps its last value in IDLE.
- `mem_respValid` is ignored in IDLE.
- The non-owner's rdata output holds its previous value.
- `busy` = (state≠IDLE) | ifu_pending | lsu_pending.

## Timing
- Reset values:
  - state IDLE; pending flags 0.
  - `last_grant`=LSU, so an IFU/LSU tie right after reset goes to IFU.
  - All `*_respValid`=0, `mem_reqValid`=0.
  - All data, address, size and mask outputs = 0; `busy`=0; `drop_err`=0.
- Asserting reset mid-transaction abandons the transaction. A `mem_respValid` that arrives after reset is ignored and produces no requester pulse.
- Latency with IFU and LSU both idle:
  - reqValid at cycle N → `mem_reqValid` at N+1.
  - `mem_respValid` at cycle M (M≥N+1) → requester respValid at M+1.
  - Minimum round trip is 2 cycles.
- Back-to-back operation: completion at M puts the FSM in IDLE at M+1. A pending request issues at M+2.
- Request and response in the same cycle: a port may issue a new reqValid in the same cycle as its own respValid. That request is accepted, not dropped.
- Simultaneous reqValid pulses from IFU and LSU in the same cycle: both are captured. One is served immediately; the other is served after the first completes.

## Test plan
- **Single fetch:** reset; `ifu_reqValid`@1 with addr 0x8000_0000; memory returns rdata 0x0010_0093 one cycle after `mem_reqValid`. Required: `mem_reqValid`@2 with addr 0x8000_0000, `mem_size`=2, `mem_wen`=0; `ifu_respValid`@4 with rdata 0x0010_0093; `busy` low @4.
- **Simultaneous requests after reset:** IFU and LSU both assert reqValid @1 (LSU: store, addr 0x100, wdata 0xDEAD_BEEF, wmask 0xF). Required: IFU issues first; the LSU store is issued 2 cycles after IFU completion, with its payload intact; `lsu_respValid` follows.
- **Alternation:** both ports re-request immediately after every response, for 6 transactions. Required: grants alternate IFU, LSU, IFU, …; neither port is granted twice in a row.
- **Drop:** while an LSU load is in WAIT, pulse `lsu_reqValid` again with addr 0x200. Required: `drop_err`=1 and stays 1; `mem_addr` remains the original address; exactly one `lsu_respValid` occurs.
- **Zero-wait memory:** `mem_respValid`=1 in the ISSUE cycle. Required: the FSM skips WAIT; the requester's respValid is high in the next cycle.
- **Reset mid-transaction:** assert reset during WAIT, then deassert; inject a late `mem_respValid`. Required: no requester respValid; all outputs at reset values; a new request then completes normally.
